// File: rtl/spi_master_tx.sv
// SPI transmit stage: serialises a DATA_W word onto sync_clock/CS/MOSI for a receiver that ignores the first
// rising edge after CS falls. Define SPI_MSB_FIRST_EN to shift MSB first (default LSB first).
module spi_master_tx #(
    parameter int DATA_W   = 12,
    parameter int CLK_DIV  = 4,
    parameter int GAP_SCLK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              done,
    output logic              sync_clock,
    output logic              CS,
    output logic              MOSI
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = (GAP_SCLK > 1) ? $clog2(GAP_SCLK) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_FALL, LEAD, SHIFT, GAP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] din_q;
    logic              div_tc, sclk_rise, sclk_fall;

    assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sclk_rise = div_tc & ~sync_clock;
    assign sclk_fall = div_tc & sync_clock;

    function automatic logic pick_bit(input logic [DATA_W-1:0] w, input logic [BIT_W-1:0] i);
`ifdef SPI_MSB_FIRST_EN
        return w[DATA_W-1-int'(i)];
`else
        return w[int'(i)];
`endif
    endfunction

    // Free-running divider: sync_clock keeps running so the receiver can close its frame after CS rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            sync_clock <= 1'b0;
        end else if (div_tc) begin
            div_cnt    <= '0;
            sync_clock <= ~sync_clock;
        end else begin
            div_cnt    <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            din_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (newd && ready) begin
                        din_q <= din;
                        ready <= 1'b0;
                        state <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (sclk_fall) begin
                        CS      <= 1'b0;
                        MOSI    <= pick_bit(din_q, '0);
                        bit_cnt <= '0;
                        state   <= LEAD;
                    end
                end
                // The rise seen here only arms the receiver; no bit is counted.
                LEAD: begin
                    if (sclk_rise) state <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) bit_cnt <= bit_cnt + 1'b1;
                    if (sclk_fall) begin
                        if (bit_cnt == BIT_W'(DATA_W)) begin
                            CS      <= 1'b1;
                            MOSI    <= 1'b0;
                            done    <= 1'b1;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            MOSI <= pick_bit(din_q, bit_cnt);
                        end
                    end
                end
                GAP: begin
                    if (sclk_fall) begin
                        if (gap_cnt == GAP_W'(GAP_SCLK - 1)) begin
                            gap_cnt <= '0;
                            ready   <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
